// File: rtl/mxv_tx_sched.sv
// Result-FIFO to UART drain: pops each result word and sends it as uppercase
// ASCII hex (MSB nibble first), followed by a space or, after the last word, CR.
module mxv_tx_sched #(
   parameter int RESULT_W = 16,
   parameter int MAX_N    = 8,
   parameter int CNT_W    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [CNT_W-1:0]    n_results,
   input  logic                res_empty,
   input  logic [RESULT_W-1:0] res_data,
   output logic                pop_result,
   input  logic                tx_busy,
   output logic                tx_start,
   output logic [7:0]          tx_data,
   output logic                busy,
   output logic                done
);

   localparam int               CHARS   = RESULT_W / 4;
   localparam int               CC_W    = $clog2(CHARS + 2);
   localparam logic [CC_W-1:0]  CHARS_C = CC_W'(CHARS);
   localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_N);

   typedef enum logic [2:0] {IDLE, POP, LATCH, CHAR, GUARD, WAIT_TX, SEP, DONE} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    n_q, n_d;
   logic [CNT_W-1:0]    word_q, word_d;
   logic [CC_W-1:0]     char_q, char_d;
   logic [RESULT_W-1:0] sh_q, sh_d;
   logic [7:0]          txd_q, txd_d;
   logic [CNT_W-1:0]    n_clamp;
   logic                last_word;

   function automatic logic [7:0] hex_char(input logic [3:0] nib);
      return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   endfunction

   assign n_clamp    = (n_results > MAX_C) ? MAX_C : n_results;
   assign last_word  = (word_q + CNT_W'(1)) >= n_q;
   assign pop_result = (state_q == POP) && !res_empty;
   assign tx_start   = ((state_q == CHAR) || (state_q == SEP)) && !tx_busy;
   assign tx_data    = txd_q;
   assign busy       = (state_q != IDLE) && (state_q != DONE);
   assign done       = (state_q == DONE);

   // tx_data is loaded on entry to CHAR/SEP so the byte is already in place
   // on the cycle tx_start fires, and holds until the next launch.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      word_d  = word_q;
      char_d  = char_q;
      sh_d    = sh_q;
      txd_d   = txd_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (n_clamp != '0) begin
                  n_d     = n_clamp;
                  word_d  = '0;
                  state_d = POP;
               end else begin
                  state_d = DONE;
               end
            end
         end
         POP: begin
            if (!res_empty) state_d = LATCH;
         end
         LATCH: begin
            sh_d    = res_data;
            char_d  = '0;
            txd_d   = hex_char(res_data[RESULT_W-1 -: 4]);
            state_d = CHAR;
         end
         CHAR: begin
            if (!tx_busy) begin
               sh_d    = sh_q << 4;
               char_d  = char_q + CC_W'(1);
               state_d = GUARD;
            end
         end
         GUARD: state_d = WAIT_TX;
         WAIT_TX: begin
            if (!tx_busy) begin
               if (char_q < CHARS_C) begin
                  txd_d   = hex_char(sh_q[RESULT_W-1 -: 4]);
                  state_d = CHAR;
               end else if (char_q == CHARS_C) begin
                  txd_d   = last_word ? 8'h0D : 8'h20;
                  state_d = SEP;
               end else if (last_word) begin
                  state_d = DONE;
               end else begin
                  if (word_q < MAX_C) word_d = word_q + CNT_W'(1);
                  state_d = POP;
               end
            end
         end
         // char counter steps past CHARS so WAIT_TX can tell a separator went out
         SEP: begin
            if (!tx_busy) begin
               char_d  = char_q + CC_W'(1);
               state_d = GUARD;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         n_q     <= '0;
         word_q  <= '0;
         char_q  <= '0;
         sh_q    <= '0;
         txd_q   <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         word_q  <= word_d;
         char_q  <= char_d;
         sh_q    <= sh_d;
         txd_q   <= txd_d;
      end
   end

endmodule

// File: doc/mxv_tx_sched.md
# mxv_tx_sched

Transmit scheduler for the matrix-vector unit: after a multiply completes, it drains a requested number of result words from the result FIFO and streams each one to the UART transmitter as uppercase ASCII hex characters. It sits between the result FIFO (drives `pop_result`) and the UART TX byte interface, and is started by the main control FSM. It mirrors the receive path's ASCII/hex conversion on the return direction.

## Interface
- `RESULT_W`, 16, result word width in bits; must be a multiple of 4; characters per word = `RESULT_W/4`.
- `MAX_N`, 8, maximum results per transfer.
- `CNT_W`, 4, width of `n_results`; must satisfy 2^`CNT_W` > `MAX_N`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a transfer; sampled only in IDLE.
- `n_results`  in  `CNT_W`  number of words to send; sampled with `start`; values above `MAX_N` are clamped to `MAX_N`.
- `res_empty`  in  1  result FIFO empty flag.
- `res_data`  in  `RESULT_W`  FIFO read data, valid the cycle after `pop_result`.
- `pop_result`  out  1  FIFO pop strobe, one cycle per word.
- `tx_busy`  in  1  UART transmitter busy.
- `tx_start`  out  1  one-cycle byte launch strobe.
- `tx_data`  out  8  byte to transmit; stable from `tx_start` until the next `tx_start`.
- `busy`  out  1  high from the cycle after an accepted `start` until the cycle `done` is asserted.
- `done`  out  1  one-cycle pulse when the transfer completes.

## Operation
- States: IDLE, POP, LATCH, CHAR, GUARD, WAIT_TX, SEP, DONE.
- **IDLE**
  - If `start`=1 and clamped `n_results`≥1: latch the count, clear the word counter, go to POP.
  - If `start`=1 and `n_results`=0: go to DONE; no bytes are sent.
- **POP:** `pop_result` = (state==POP && !`res_empty`).
  - If `res_empty`=1: stay in POP (stall indefinitely, no pop).
  - Otherwise go to LATCH.
- **LATCH:** register `res_data` into the shift register, clear the char counter, go to CHAR.
- **CHAR:** wait until `tx_busy`=0. Then pulse `tx_start`, drive `tx_data` from the top nibble (MSB first), shift the word left by 4, increment the char counter, and go to GUARD.
- **GUARD:** one cycle in which `tx_busy` is ignored; this covers the TX flag rising one cycle late. Then go to WAIT_TX.
- **WAIT_TX:** wait for `tx_busy`=0.
  - If chars sent < `RESULT_W/4`: go to CHAR.
  - Else: go to SEP.
- **SEP:** wait until `tx_busy`=0, then send a separator with the same GUARD/WAIT_TX protocol.
  - Separator is 0x20 (space) if more words remain; increment the word counter and return to POP.
  - Separator is 0x0D (CR) after the last word; go to DONE.
- **DONE:** `done`=1 for one cycle, then go to IDLE.
- Hex encoding: nibble 0–9 → 0x30+n; nibble 10–15 → 0x41+(n−10) (uppercase).
- Counters saturate at `MAX_N` and never wrap mid-transfer.
- `start` is ignored in any state other than IDLE.

## Timing
- Reset values: state IDLE; `pop_result`, `tx_start`, `busy`, `done` = 0; `tx_data` = 0x00; all counters and the shift register = 0.
- Reset asserted mid-transfer: immediate return to IDLE with the reset values above. A byte already handed to TX is not tracked. FIFO contents not yet popped stay in the FIFO.
- Cycle-level latencies (`start` sampled at edge k, FIFO non-empty, `tx_busy`=0):
  - k+1: `pop_result`=1.
  - k+2: LATCH.
  - k+3: first `tx_start`=1.
- Minimum spacing between `tx_start` pulses is 3 cycles (CHAR, GUARD, WAIT_TX) when `tx_busy` never rises.
- `pop_result` and `tx_start` are never asserted in the same cycle.
- Each word produces exactly `RESULT_W/4`+1 `tx_start` pulses.
- N=0: `done` pulses at k+1 and `busy` stays 0.

## Test plan
- `n_results`=1, FIFO holds 0x1A2F, `tx_busy` tied 0 → bytes 0x31, 0x41, 0x32, 0x46, 0x0D; one `pop_result`; `done` 3 cycles after the last `tx_start`.
- `n_results`=2, FIFO holds 0x0000 then 0xFFFF, TX model busy 10 cycles per byte → "0000 FFFF\r"; no `tx_start` while `tx_busy`=1; exactly 2 pops.
- `n_results`=3 with FIFO empty for 20 cycles after start, then filled → no pop during the stall, state held in POP, correct 15-byte stream afterwards.
- `start` pulsed again mid-transfer, and `n_results`=12 → second start ignored; the clamped transfer sends 8 words, 40 bytes.
- `rst` driven low during the third character of word 1 → all outputs 0 in the same cycle; a fresh `start` after release sends the next FIFO word from its first character.
- `n_results`=0 → `done` pulse at k+1, no `pop_result`, no `tx_start`.
